line_fill_memory: RTL and testbench
===================================

Name: line_fill_memory

Overview:
- Backing-memory responder on the refill side of the L1 cache.
- Accepts one miss-fill or write-through request at a time over a valid/ready handshake.
- After a fixed, parameterised latency it returns the full 32-byte line for reads, or commits a single byte for writes.
- The line is driven on a 32-entry byte array that feeds the cache's line-fill input.

Parameters:
- ADDR_WIDTH, 11: byte address width. Memory depth is 2**ADDR_WIDTH bytes.
- LINE_BYTES, 32: bytes per line. Must be a power of 2. Offset is the low log2(LINE_BYTES) address bits.
- READ_LATENCY, 4: cycles from request accept to read response. Legal range 1..255.
- WRITE_LATENCY, 2: cycles from request accept to write commit/response. Legal range 1..255.
- INIT_BASE, 8'hC0: initial content is mem[a] = INIT_BASE + a[4:0], mod 256.

Ports:
- clk, in, 1: clock. All logic is on the rising edge.
- rst, in, 1: synchronous active-high reset.
- req_valid, in, 1: request present.
- req_rw, in, 1: 0 = line read (fill), 1 = byte write.
- req_address, in, ADDR_WIDTH: byte address.
- req_write_data, in, 8: write byte.
- req_ready, out, 1: responder can accept a request.
- resp_valid, out, 1: one-cycle completion pulse.
- resp_rw, out, 1: type of the completed request.
- oRAM32, out, 8 x LINE_BYTES (unpacked [0:LINE_BYTES-1]): returned line.
- read_count, out, 32: completed reads.
- write_count, out, 32: completed writes.

Behaviour:
- Reset and initial values:
  - Memory array is initialised at time zero per INIT_BASE. rst does NOT clear memory.
  - On rst, outputs take: req_ready=1, resp_valid=0, resp_rw=0, oRAM32 all 8'h00, read_count=0, write_count=0. FSM goes to IDLE.
- FSM states: IDLE, READ_WAIT, WRITE_WAIT, RESPOND.
- IDLE:
  - req_ready=1.
  - Accept occurs on a rising edge where req_valid && req_ready.
  - On accept, latch address, rw and write data. Load the latency counter with READ_LATENCY-1 or WRITE_LATENCY-1.
  - Go to READ_WAIT or WRITE_WAIT.
- READ_WAIT / WRITE_WAIT:
  - req_ready=0. req_valid is ignored; there is no queue and requests are not dropped silently, since the requester must hold them.
  - Counter decrements each cycle.
  - On the edge where the counter is 0, go to RESPOND.
- Completing edge, read:
  - oRAM32[i] <= mem[{line_index, i}] for i = 0..LINE_BYTES-1.
  - The offset bits are ignored; the line is aligned.
  - read_count increments.
- Completing edge, write:
  - mem[latched address] <= latched data.
  - write_count increments.
  - oRAM32 is unchanged.
- RESPOND:
  - resp_valid=1 and resp_rw = latched rw, for exactly one cycle. req_ready=0.
  - Next edge returns to IDLE.
- Latency: with accept at edge N, resp_valid is high in the cycle after edge N+LATENCY. The earliest next accept is edge N+LATENCY+2.
- oRAM32 holds the last read line until the next read completes or rst.
- Consistency: a read issued after a write completes returns the written byte. With one request outstanding there are no hazards.
- Address wrap: addresses use ADDR_WIDTH bits only. Line index = address[ADDR_WIDTH-1:log2(LINE_BYTES)].
- Counters wrap modulo 2**32.
- Reset mid-operation:
  - The transaction is aborted. No resp_valid is produced.
  - A write whose commit edge has not yet occurred is NOT committed.
  - If rst coincides with the commit edge, rst wins: no commit, no count.
- Simultaneous req_valid and rst: rst wins; the request is not accepted.

Test Plan:
- Reset then read at 11'h120: req_ready drops on the edge after accept. resp_valid pulses 5 cycles after accept (READ_LATENCY=4). oRAM32[i]=8'hC0+i, read_count=1.
- Read at 11'h13F (offset 31): returns the same line as 11'h120, oRAM32[0]=8'hC0 and oRAM32[31]=8'hDF.
- Write 8'hAA to 11'h125, then read 11'h120: write resp_valid arrives with resp_rw=1 after WRITE_LATENCY. The read gives oRAM32[5]=8'hAA and the other bytes unchanged. write_count=1, read_count=1.
- Hold req_valid high continuously with alternating addresses: exactly one accept per transaction. req_ready=0 throughout WAIT and RESPOND. Back-to-back period is LATENCY+2 cycles.
- Write 8'h55 to 11'h7E0, then assert rst one cycle after accept (before commit): no resp_valid, write_count=0. A subsequent read of 11'h7E0 returns oRAM32[0]=8'hC0.
- Read during rst with req_valid=1: not accepted. After rst deasserts, the request is accepted on the next edge and completes normally.

Source files
------------

// File: rtl/line_fill_memory_if.sv
// rtl/line_fill_memory_if.sv - request/response bundle between the L1 refill path and backing memory
interface line_fill_memory_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int LINE_BYTES = 32
);
  logic                  req_valid;
  logic                  req_rw;
  logic [ADDR_WIDTH-1:0] req_address;
  logic [7:0]            req_write_data;
  logic                  req_ready;
  logic                  resp_valid;
  logic                  resp_rw;
  logic [7:0]            oRAM32 [0:LINE_BYTES-1];

  modport master (
    output req_valid, req_rw, req_address, req_write_data,
    input  req_ready, resp_valid, resp_rw, oRAM32
  );

  modport slave (
    input  req_valid, req_rw, req_address, req_write_data,
    output req_ready, resp_valid, resp_rw, oRAM32
  );
endinterface

// File: rtl/line_fill_memory.sv
// rtl/line_fill_memory.sv - refill-side backing memory: fixed-latency line reads and byte writes
module line_fill_memory #(
  parameter int         ADDR_WIDTH    = 11,
  parameter int         LINE_BYTES    = 32,
  parameter int         READ_LATENCY  = 4,
  parameter int         WRITE_LATENCY = 2,
  parameter logic [7:0] INIT_BASE     = 8'hC0
) (
  input  logic               clk,
  input  logic               rst,
  line_fill_memory_if.slave  bus,
  output logic [31:0]        read_count,
  output logic [31:0]        write_count
);
  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int IDX_W = ADDR_WIDTH - OFF_W;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RESPOND} state_t;

  state_t                state;
  logic [7:0]            lat_cnt;
  logic                  rw_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            data_q;

  // Bytes never written read back their power-on formula value, so the
  // array itself needs no preload; only the written flags start cleared.
  logic [7:0]            mem [0:DEPTH-1];
  logic [DEPTH-1:0]      written = '0;

  logic                  commit_wr;
  logic [IDX_W-1:0]      line_idx;

  assign commit_wr = (state == WRITE_WAIT) && (lat_cnt == 8'd0);
  assign line_idx  = addr_q[ADDR_WIDTH-1:OFF_W];

  function automatic logic [7:0] mem_byte(input logic [ADDR_WIDTH-1:0] a);
    return written[a] ? mem[a] : 8'(INIT_BASE + {3'b000, a[4:0]});
  endfunction

  // rst blocks the commit so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (!rst && commit_wr) begin
      mem[addr_q]     <= data_q;
      written[addr_q] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      lat_cnt        <= '0;
      rw_q           <= 1'b0;
      addr_q         <= '0;
      data_q         <= '0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_rw    <= 1'b0;
      for (int i = 0; i < LINE_BYTES; i++) bus.oRAM32[i] <= 8'h00;
      read_count     <= '0;
      write_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            rw_q          <= bus.req_rw;
            addr_q        <= bus.req_address;
            data_q        <= bus.req_write_data;
            lat_cnt       <= bus.req_rw ? 8'(WRITE_LATENCY - 1) : 8'(READ_LATENCY - 1);
            state         <= bus.req_rw ? WRITE_WAIT : READ_WAIT;
            bus.req_ready <= 1'b0;
          end
        end
        READ_WAIT, WRITE_WAIT: begin
          if (lat_cnt == 8'd0) begin
            state          <= RESPOND;
            bus.resp_valid <= 1'b1;
            bus.resp_rw    <= rw_q;
            if (state == READ_WAIT) begin
              for (int i = 0; i < LINE_BYTES; i++)
                bus.oRAM32[i] <= mem_byte({line_idx, OFF_W'(i)});
              read_count <= read_count + 32'd1;
            end else begin
              write_count <= write_count + 32'd1;
            end
          end else begin
            lat_cnt <= lat_cnt - 8'd1;
          end
        end
        RESPOND: begin
          state          <= IDLE;
          bus.resp_valid <= 1'b0;
          bus.req_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_line_fill_memory.sv
// tb/tb_line_fill_memory.sv - directed bench for line_fill_memory
module tb_line_fill_memory;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] read_count;
  logic [31:0] write_count;
  int          n_pass  = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  line_fill_memory_if #(.ADDR_WIDTH(11), .LINE_BYTES(32)) bus ();

  line_fill_memory #(
    .ADDR_WIDTH(11), .LINE_BYTES(32), .READ_LATENCY(4), .WRITE_LATENCY(2), .INIT_BASE(8'hC0)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .read_count(read_count), .write_count(write_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Called at a negedge with the responder idle; returns at the negedge after the pulse.
  task automatic do_req(input string tag, input logic rw, input logic [10:0] addr,
                        input logic [7:0] data, input int exp_lat);
    int cyc = 0;
    bus.req_valid      = 1'b1;
    bus.req_rw         = rw;
    bus.req_address    = addr;
    bus.req_write_data = data;
    @(posedge clk);
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        check({tag, "_ready_low"}, 32'(bus.req_ready), 32'd0);
        bus.req_valid = 1'b0;
      end
      if (bus.resp_valid) break;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_resp_rw"}, 32'(bus.resp_rw), 32'(rw));
    @(negedge clk);
    check({tag, "_pulse_end"}, 32'(bus.resp_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    int accepts, resp_seen, ready_low, first_acc, second_acc, cyc;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_rw = 1'b0; bus.req_address = '0; bus.req_write_data = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_rw", 32'(bus.resp_rw), 32'd0);
    check("rst_line0", 32'(bus.oRAM32[0]), 32'h00);
    check("rst_line31", 32'(bus.oRAM32[31]), 32'h00);
    check("rst_rd_count", read_count, 32'd0);
    check("rst_wr_count", write_count, 32'd0);
    rst = 1'b0;

    do_req("rd120", 1'b0, 11'h120, 8'h00, 5);
    for (int i = 0; i < 32; i++)
      check($sformatf("rd120_b%0d", i), 32'(bus.oRAM32[i]), 32'hC0 + 32'(i));
    check("rd120_count", read_count, 32'd1);

    do_req("rd13f", 1'b0, 11'h13F, 8'h00, 5);
    check("rd13f_b0", 32'(bus.oRAM32[0]), 32'hC0);
    check("rd13f_b31", 32'(bus.oRAM32[31]), 32'hDF);

    do_req("wr125", 1'b1, 11'h125, 8'hAA, 3);
    check("wr125_count", write_count, 32'd1);
    check("wr125_line_kept", 32'(bus.oRAM32[5]), 32'hC5);
    do_req("rd120b", 1'b0, 11'h120, 8'h00, 5);
    check("rd120b_b4", 32'(bus.oRAM32[4]), 32'hC4);
    check("rd120b_b5", 32'(bus.oRAM32[5]), 32'hAA);
    check("rd120b_b6", 32'(bus.oRAM32[6]), 32'hC6);
    check("rd120b_count", read_count, 32'd3);

    // Continuous req_valid: one accept every READ_LATENCY+2 cycles.
    accepts = 0; resp_seen = 0; ready_low = 0; first_acc = -1; second_acc = -1;
    bus.req_valid = 1'b1; bus.req_rw = 1'b0; bus.req_address = 11'h040;
    for (int c = 0; c < 14; c++) begin
      if (bus.resp_valid) resp_seen++;
      if (bus.req_ready) begin
        accepts++;
        if (first_acc < 0) first_acc = c;
        else if (second_acc < 0) second_acc = c;
        @(posedge clk);
        @(negedge clk);
        bus.req_address = (bus.req_address == 11'h040) ? 11'h7C0 : 11'h040;
      end else begin
        ready_low++;
        @(negedge clk);
      end
    end
    bus.req_valid = 1'b0;
    check("stream_accepts", 32'(accepts), 32'd3);
    check("stream_period", 32'(second_acc - first_acc), 32'd6);
    check("stream_ready_low", 32'(ready_low), 32'd11);
    check("stream_resps", 32'(resp_seen), 32'd2);
    cyc = 0;
    while (cyc < 20 && !bus.resp_valid) begin @(negedge clk); cyc++; end
    check("stream_last_resp", 32'(bus.resp_valid), 32'd1);
    check("stream_rd_count", read_count, 32'd6);
    @(negedge clk);

    // Reset one cycle after accepting a write, before its commit edge.
    bus.req_valid = 1'b1; bus.req_rw = 1'b1; bus.req_address = 11'h7E0; bus.req_write_data = 8'h55;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    resp_seen = 0;
    repeat (6) begin @(negedge clk); if (bus.resp_valid) resp_seen++; end
    check("abort_no_resp", 32'(resp_seen), 32'd0);
    check("abort_wr_count", write_count, 32'd0);
    check("abort_ready", 32'(bus.req_ready), 32'd1);
    do_req("rd7e0", 1'b0, 11'h7E0, 8'h00, 5);
    check("rd7e0_b0", 32'(bus.oRAM32[0]), 32'hC0);
    check("rd7e0_count", read_count, 32'd1);

    // Request presented during reset is not taken until reset drops.
    rst = 1'b1;
    bus.req_valid = 1'b1; bus.req_rw = 1'b0; bus.req_address = 11'h125;
    @(negedge clk);
    check("rstreq_ready", 32'(bus.req_ready), 32'd1);
    check("rstreq_rd_count", read_count, 32'd0);
    rst = 1'b0;
    do_req("rd125", 1'b0, 11'h125, 8'h00, 5);
    check("rd125_b5_kept", 32'(bus.oRAM32[5]), 32'hAA);
    check("rd125_b0", 32'(bus.oRAM32[0]), 32'hC0);
    check("rd125_count", read_count, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
